// File: rtl/d_fetch_queue_pkg.sv
// Shared constants for the F->D fetch queue: default widths, boot and handler PCs,
// ExcCode values and small PC helpers.
package d_fetch_queue_pkg;

   localparam int          EXC_W_DEF      = 5;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

   // ExcCode values; the queue carries them opaquely and never interprets them
   localparam logic [EXC_W_DEF-1:0] EXC_INT  = 5'd0;
   localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 5'd8;
   localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] pc_link(input logic [31:0] pc);
      return pc + 32'd8;
   endfunction

endpackage

// File: rtl/d_fetch_queue_storage.sv
// Entry array for the fetch queue: synchronous write, asynchronous (combinational) read.
// No reset: validity is tracked entirely by the pointers and count in the parent.
module fq_storage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 70
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/d_fetch_queue.sv
// F->D instruction queue with optional same-cycle bypass when empty (FWFT) and flush.
// enq_ready = !full (registered count only); head is held stable while deq_ready is low.
module d_fetch_queue
   import d_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter bit          FWFT     = 1'b1,
   parameter int          EXC_W    = EXC_W_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [31:0]                flush_pc,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [31:0]                enq_instr,
   input  logic [31:0]                enq_pc,
   input  logic [EXC_W-1:0]           enq_exccode,
   input  logic                       enq_bd,
   input  logic                       deq_ready,
   output logic                       deq_valid,
   output logic [31:0]                deq_instr,
   output logic [31:0]                deq_pc,
   output logic [31:0]                deq_pc8,
   output logic [EXC_W-1:0]           deq_exccode,
   output logic                       deq_bd,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = 32 + 32 + EXC_W + 1;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic [31:0]   bubble_pc;

   logic          full;
   logic          empty;
   logic          bypass;
   logic          enq_fire;
   logic          deq_fire;
   logic          pass_through;
   logic          st_wr;
   logic          st_rd;

   logic [EW-1:0]    wr_data;
   logic [EW-1:0]    rd_data;
   logic [31:0]      head_instr;
   logic [31:0]      head_pc;
   logic [EXC_W-1:0] head_exc;
   logic             head_bd;

   assign full      = (cnt == CW'(DEPTH));
   assign empty     = (cnt == '0);
   assign enq_ready = ~full;
   assign count     = cnt;

   assign bypass    = FWFT && empty && enq_valid;
   assign deq_valid = ~empty | bypass;

   assign enq_fire  = enq_valid & enq_ready & ~flush;
   assign deq_fire  = deq_valid & deq_ready & ~flush;

   // A dequeue on an empty queue can only be the bypassed enqueue: it never touches storage.
   assign pass_through = empty & deq_fire;
   assign st_wr        = enq_fire & ~pass_through & reset;
   assign st_rd        = deq_fire & ~pass_through;

   assign wr_data = {enq_instr, enq_pc, enq_exccode, enq_bd};
   assign {head_instr, head_pc, head_exc, head_bd} = rd_data;

   fq_storage #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_storage (
      .clk     (clk),
      .wr_en   (st_wr),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         bubble_pc <= RESET_PC;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         bubble_pc <= flush_pc;
      end else begin
         if (st_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (st_rd) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({st_wr, st_rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (enq_fire) begin
            bubble_pc <= pc_next(enq_pc);
         end
      end
   end

   always_comb begin
      deq_instr   = 32'h0;
      deq_pc      = bubble_pc;
      deq_exccode = '0;
      deq_bd      = 1'b0;
      if (!empty) begin
         deq_instr   = head_instr;
         deq_pc      = head_pc;
         deq_exccode = head_exc;
         deq_bd      = head_bd;
      end else if (bypass) begin
         deq_instr   = enq_instr;
         deq_pc      = enq_pc;
         deq_exccode = enq_exccode;
         deq_bd      = enq_bd;
      end
   end

   assign deq_pc8 = pc_link(deq_pc);

endmodule

// File: tb/tb_d_fetch_queue.sv
// Randomised and directed bench for d_fetch_queue against a queue-based behavioural model.
module tb_d_fetch_queue;

   localparam int          DEPTH = 4;
   localparam int          EXC_W = 5;
   localparam logic [31:0] RPC   = 32'h0000_3000;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic [31:0]      flush_pc;
   logic             enq_valid;
   logic             enq_ready;
   logic [31:0]      enq_instr;
   logic [31:0]      enq_pc;
   logic [EXC_W-1:0] enq_exccode;
   logic             enq_bd;
   logic             deq_ready;
   logic             deq_valid;
   logic [31:0]      deq_instr;
   logic [31:0]      deq_pc;
   logic [31:0]      deq_pc8;
   logic [EXC_W-1:0] deq_exccode;
   logic             deq_bd;
   logic [2:0]       count;

   int n_chk = 0;
   int n_err = 0;

   d_fetch_queue #(
      .DEPTH(DEPTH), .FWFT(1'b1), .EXC_W(EXC_W), .RESET_PC(RPC)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr),
      .enq_pc(enq_pc), .enq_exccode(enq_exccode), .enq_bd(enq_bd),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr),
      .deq_pc(deq_pc), .deq_pc8(deq_pc8), .deq_exccode(deq_exccode),
      .deq_bd(deq_bd), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the queue contents as a list plus the bubble PC.
   typedef struct {
      logic [31:0]      instr;
      logic [31:0]      pc;
      logic [EXC_W-1:0] exc;
      logic             bd;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_bubble = RPC;

   always @(negedge clk) begin
      logic             e_v;
      logic [31:0]      e_instr;
      logic [31:0]      e_pc;
      logic [EXC_W-1:0] e_exc;
      logic             e_bd;
      logic             e_fire;
      logic             d_fire;
      ent_t             ne;
      if (mq.size() != 0) begin
         e_v = 1'b1; e_instr = mq[0].instr; e_pc = mq[0].pc; e_exc = mq[0].exc; e_bd = mq[0].bd;
      end else if (enq_valid) begin
         e_v = 1'b1; e_instr = enq_instr; e_pc = enq_pc; e_exc = enq_exccode; e_bd = enq_bd;
      end else begin
         e_v = 1'b0; e_instr = 32'h0; e_pc = m_bubble; e_exc = '0; e_bd = 1'b0;
      end
      chk("deq_valid", {31'd0, deq_valid}, {31'd0, e_v});
      chk("deq_instr", deq_instr, e_instr);
      chk("deq_pc", deq_pc, e_pc);
      chk("deq_pc8", deq_pc8, e_pc + 32'd8);
      chk("deq_exccode", {27'd0, deq_exccode}, {27'd0, e_exc});
      chk("deq_bd", {31'd0, deq_bd}, {31'd0, e_bd});
      chk("count", {29'd0, count}, mq.size());
      chk("enq_ready", {31'd0, enq_ready}, {31'd0, (mq.size() < DEPTH)});

      if (!reset) begin
         mq.delete();
         m_bubble = RPC;
      end else if (flush) begin
         mq.delete();
         m_bubble = flush_pc;
      end else begin
         e_fire = enq_valid && (mq.size() < DEPTH);
         d_fire = e_v && deq_ready;
         if (mq.size() == 0 && d_fire) begin
            m_bubble = enq_pc + 32'd4;
         end else begin
            if (d_fire) void'(mq.pop_front());
            if (e_fire) begin
               ne.instr = enq_instr; ne.pc = enq_pc; ne.exc = enq_exccode; ne.bd = enq_bd;
               mq.push_back(ne);
               m_bubble = enq_pc + 32'd4;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [EXC_W-1:0] exc, input logic bd, input logic dr);
      enq_valid = v; enq_pc = pc; enq_instr = ins; enq_exccode = exc; enq_bd = bd;
      deq_ready = dr;
   endtask

   task automatic drain();
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 12 && count != 0; k++) tick();
   endtask

   logic [31:0] obs[$];

   initial begin
      int idx;
      logic fire;
      reset = 1'b0; flush = 1'b0; flush_pc = 32'h0;
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b1;

      // reset then idle
      look();
      chk("rst_valid", {31'd0, deq_valid}, 32'd0);
      chk("rst_instr", deq_instr, 32'h0);
      chk("rst_pc", deq_pc, 32'h3000);
      chk("rst_pc8", deq_pc8, 32'h3008);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_ready", {31'd0, enq_ready}, 32'd1);
      tick();

      // fill while stalled
      for (int i = 0; i < 4; i++) begin
         put(1'b1, 32'h3000 + 32'(4 * i), 32'h1000 + 32'(i), '0, 1'b0, 1'b0);
         tick();
      end
      put(1'b1, 32'h3010, 32'h1004, '0, 1'b0, 1'b0);
      look();
      chk("fill_count", {29'd0, count}, 32'd4);
      chk("fill_ready", {31'd0, enq_ready}, 32'd0);
      tick();
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
      look();
      chk("fill5_count", {29'd0, count}, 32'd4);
      chk("fill_head", deq_pc, 32'h3000);
      tick();
      drain();

      // wrap-around with occasional stalls
      idx = 0;
      obs.delete();
      for (int c = 0; c < 80 && (idx < 10 || count != 0); c++) begin
         put(idx < 10, 32'h3000 + 32'(4 * idx), 32'h2000 + 32'(idx), '0, 1'b0, (c % 3) != 2);
         look();
         fire = enq_valid && enq_ready;
         if (deq_valid && deq_ready) obs.push_back(deq_pc);
         if (count > 4) chk("wrap_count_max", {29'd0, count}, 32'd4);
         tick();
         if (fire) idx++;
      end
      chk("wrap_n", obs.size(), 32'd10);
      for (int k = 0; k < obs.size() && k < 10; k++) chk("wrap_pc", obs[k], 32'h3000 + 32'(4 * k));
      drain();

      // FWFT bypass on empty queue
      put(1'b1, 32'h3040, 32'h2408_0001, '0, 1'b0, 1'b1);
      look();
      chk("byp_valid", {31'd0, deq_valid}, 32'd1);
      chk("byp_pc", deq_pc, 32'h3040);
      chk("byp_instr", deq_instr, 32'h2408_0001);
      tick();
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b1);
      look();
      chk("byp_count", {29'd0, count}, 32'd0);
      chk("byp_bubble_pc", deq_pc, 32'h3044);
      chk("byp_bubble_valid", {31'd0, deq_valid}, 32'd0);
      tick();

      // flush with 3 entries and a simultaneous enqueue
      for (int i = 0; i < 3; i++) begin
         put(1'b1, 32'h3100 + 32'(4 * i), 32'h3000 + 32'(i), 5'd3, 1'b0, 1'b0);
         tick();
      end
      flush = 1'b1; flush_pc = 32'h0000_4180;
      put(1'b1, 32'h3200, 32'hdead_beef, 5'd7, 1'b1, 1'b1);
      tick();
      flush = 1'b0;
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
      look();
      chk("fl_count", {29'd0, count}, 32'd0);
      chk("fl_valid", {31'd0, deq_valid}, 32'd0);
      chk("fl_pc", deq_pc, 32'h4180);
      chk("fl_exc", {27'd0, deq_exccode}, 32'd0);
      deq_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         look();
         chk("fl_dropped", {31'd0, deq_valid}, 32'd0);
      end
      tick();

      // exception passthrough, then reset while full
      put(1'b1, 32'h3300, 32'h0, 5'd4, 1'b1, 1'b0);
      tick();
      for (int i = 1; i < 4; i++) begin
         put(1'b1, 32'h3300 + 32'(4 * i), 32'h4000 + 32'(i), '0, 1'b0, 1'b0);
         tick();
      end
      put(1'b1, 32'h3400, 32'h1, '0, 1'b0, 1'b1);
      reset = 1'b0; flush = 1'b1; flush_pc = 32'h5000;
      look();
      chk("exc_count", {29'd0, count}, 32'd4);
      chk("exc_code", {27'd0, deq_exccode}, 32'd4);
      chk("exc_bd", {31'd0, deq_bd}, 32'd1);
      chk("exc_pc", deq_pc, 32'h3300);
      tick();
      reset = 1'b1; flush = 1'b0;
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
      look();
      chk("rst2_count", {29'd0, count}, 32'd0);
      chk("rst2_valid", {31'd0, deq_valid}, 32'd0);
      chk("rst2_pc", deq_pc, 32'h3000);
      chk("rst2_pc8", deq_pc8, 32'h3008);
      chk("rst2_ready", {31'd0, enq_ready}, 32'd1);
      tick();

      // randomised traffic
      for (int c = 0; c < 2000; c++) begin
         reset    = ($urandom_range(0, 99) != 0);
         flush    = ($urandom_range(0, 99) < 3);
         flush_pc = {$urandom_range(0, 16'hffff), 2'b00} + 32'hffff_0000;
         put($urandom_range(0, 9) < 7, $urandom() | 32'hffff_fff0, $urandom(),
             EXC_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 6);
         tick();
      end

      reset = 1'b1; flush = 1'b0;
      put(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/d_fetch_queue.md
Name: d_fetch_queue

Overview:
- Parametrised instruction buffer between the F and D stages; it is the next generation of the single-entry D-stage pipeline register.
- Holds up to DEPTH fetched instructions with their PC, exception code and branch-delay flag.
- Decouples fetch from D-stage stalls: F keeps enqueuing while D is stalled.
- Supports a flush (interrupt/eret) that empties the queue and redirects the bubble PC, and an optional same-cycle bypass when empty.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- FWFT, 1, 1 = an empty queue forwards the enqueue straight to the outputs in the same cycle; 0 = minimum one-cycle latency.
- EXC_W, 5, ExcCode width.
- RESET_PC, 32'h0000_3000, bubble PC after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all entries; asserted for IntReq or eret.
- flush_pc  in  32  bubble PC loaded on flush.
- enq_valid  in  1  F presents an instruction.
- enq_ready  out  1  queue can accept; equals !full.
- enq_instr  in  32  fetched instruction.
- enq_pc  in  32  its PC.
- enq_exccode  in  EXC_W  F-stage exception code (0 = none).
- enq_bd  in  1  branch-delay-slot flag.
- deq_ready  in  1  D consumes the head this cycle; equals !Stall.
- deq_valid  out  1  head is a real instruction.
- deq_instr  out  32  head instruction; 32'h0 (nop) when not valid.
- deq_pc  out  32  head PC; bubble PC when not valid.
- deq_pc8  out  32  deq_pc + 8.
- deq_exccode  out  EXC_W  head ExcCode; 0 when not valid.
- deq_bd  out  1  head BD flag; 0 when not valid.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH. count is a separate register, not derived from the pointers.
- full = (count == DEPTH); empty = (count == 0).
- Fire rules: enq_fire = enq_valid & enq_ready & !flush; deq_fire = deq_valid & deq_ready & !flush.
- Reset (reset == 0 at the clock edge):
  - rd_ptr = wr_ptr = count = 0.
  - bubble_pc = RESET_PC.
  - Outputs after reset: deq_valid = 0, deq_instr = 0, deq_pc = RESET_PC, deq_pc8 = RESET_PC + 8, deq_exccode = 0, deq_bd = 0, enq_ready = 1.
  - Reset overrides flush and any enqueue in the same cycle.
- Enqueue: on enq_fire, write {instr, pc, exccode, bd} at wr_ptr, then wr_ptr += 1 and bubble_pc = enq_pc + 4.
- Dequeue: on deq_fire, rd_ptr += 1.
- count update:
  - +1 for enq_fire alone; -1 for deq_fire alone; unchanged when both fire.
  - Simultaneous enq/deq on a non-full queue is legal.
  - When full, enq_ready = 0 even if deq_fire; there is no combinational ready path from deq_ready.
- Outputs, by case:
  - Non-empty: combinational read of the rd_ptr entry; deq_valid = 1.
  - Empty, FWFT = 1 and enq_valid = 1: outputs equal the enq_* inputs and deq_valid = 1. If deq_ready is also 1, the item passes through without being stored; count and pointers are unchanged and bubble_pc = enq_pc + 4.
  - Empty otherwise: bubble outputs (instr 0, pc = bubble_pc, exccode 0, bd 0, deq_valid 0).
  - deq_pc8 = deq_pc + 8 with 32-bit wrap.
- Flush (reset == 1, flush == 1) at the next edge:
  - count = 0; rd_ptr = wr_ptr = 0; bubble_pc = flush_pc.
  - Any enqueue in the flush cycle is dropped; no dequeue is counted.
  - Outputs in the cycle after the flush are the bubble with deq_pc = flush_pc.
- Stall hold: with deq_ready = 0 the head outputs are stable cycle to cycle, provided no flush occurs.
- The block never decodes the instruction: exception codes pass through unmodified.

Decomposition:
- Shared package/macro file: EXC_W default, RESET_PC and the exception-handler PC (32'h0000_4180) as named constants, next to the existing ExcCode macros.
- One sub-module, fq_storage: DEPTH x (32+32+EXC_W+1) register array with a synchronous write port and an asynchronous read port.
- Pointers, count, bubble_pc and bypass muxing live in d_fetch_queue.

Test Plan:
- Reset then idle: deq_valid 0, deq_instr 0, deq_pc 0x3000, deq_pc8 0x3008, count 0, enq_ready 1.
- Fill with deq_ready = 0, DEPTH = 4, pc 0x3000..0x300C: count reaches 4, enq_ready drops to 0. A 5th enq_valid is ignored. Head stays pc 0x3000.
- Wrap-around: 10 enqueues with continuous deq_ready = 1 and occasional 1-cycle deq stalls: output PCs exactly 0x3000, 0x3004, ... 0x3024 in order, none lost or duplicated, count never exceeds 4.
- FWFT bypass, empty: enq pc 0x3040, instr 0x24080001, deq_ready 1 in the same cycle: deq_pc 0x3040 that cycle, count stays 0, next-cycle bubble deq_pc 0x3044.
- Flush with 3 entries plus a simultaneous enq, flush_pc 0x4180: next cycle count 0, deq_valid 0, deq_pc 0x4180, deq_exccode 0; the dropped enq never appears.
- Exception passthrough: enq exccode 4 (AdEL), bd 1, instr 0: dequeued with exccode 4, bd 1; then reset = 0 for one cycle while full clears everything to the reset values.
